jk_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one bank of JK flip-flops among four requesters. Each cycle it picks at most one pending requester and applies that requester's per-bit J/K vector to the bank on the next rising clock edge. A registered one-hot grant acknowledges the update. The block sits between independent control agents and a shared JK register bank, for example status flags or mode bits, so that concurrent set/reset/toggle requests are serialised and never merged.

---
 rtl/jk_bank_arbiter_pkg.sv | 31 +++
 rtl/jk_bank_arbiter_jk_bank.sv | 35 +++
 rtl/jk_bank_arbiter.sv | 67 ++++++
 tb/tb_jk_bank_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/jk_bank_arbiter_pkg.sv
// rtl/jk_bank_arbiter_pkg.sv - shared defaults, round-robin pick and JK next-state helpers
package jk_bank_arbiter_pkg;

  localparam int N_REQ_DEFAULT  = 4;
  localparam int N_BITS_DEFAULT = 8;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Scan downward so the candidate closest to ptr is written last and wins.
  function automatic pick_t rr_pick(input logic [3:0] eligible, input logic [1:0] ptr);
    pick_t      p;
    logic [1:0] cand;
    p = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (eligible[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_jk_bank.sv
// rtl/jk_bank_arbiter_jk_bank.sv - N_BITS-wide JK register bank with enable
module jk_bank
  import jk_bank_arbiter_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_BITS-1:0] j,
  input  logic [N_BITS-1:0] k,
  output logic [N_BITS-1:0] q,
  output logic [N_BITS-1:0] qbar
);

  logic [N_BITS-1:0] d;

  always_comb begin
    d = '0;
    for (int b = 0; b < N_BITS; b++) begin
      d[b] = jk_next(j[b], k[b], q[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter serialising four requesters onto one JK bank
module jk_bank_arbiter
  import jk_bank_arbiter_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEFAULT,
  parameter int N_REQ  = N_REQ_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*N_BITS-1:0] j_in,
  input  logic [N_REQ*N_BITS-1:0] k_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_BITS-1:0]       q,
  output logic [N_BITS-1:0]       qbar,
  output logic                    busy
);

  localparam logic [N_REQ-1:0] ONE = 1;

  logic [1:0]        rr_ptr;
  logic [N_REQ-1:0]  eligible;
  pick_t             pick;
  logic [N_BITS-1:0] j_sel;
  logic [N_BITS-1:0] k_sel;

  // Last cycle's winner sits out one cycle so a held req cannot monopolise the bank.
  assign eligible = req & ~gnt;
  assign pick     = rr_pick(eligible, rr_ptr);
  assign busy     = |req;

  always_comb begin
    j_sel = '0;
    k_sel = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (pick.idx == 2'(r)) begin
        j_sel = j_in[r*N_BITS +: N_BITS];
        k_sel = k_in[r*N_BITS +: N_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      rr_ptr <= '0;
    end else if (pick.found) begin
      gnt    <= ONE << pick.idx;
      rr_ptr <= pick.idx + 2'd1;
    end else begin
      gnt    <= '0;
    end
  end

  jk_bank #(
    .N_BITS(N_BITS)
  ) u_bank (
    .clk (clk),
    .rst (rst),
    .en  (pick.found),
    .j   (j_sel),
    .k   (k_sel),
    .q   (q),
    .qbar(qbar)
  );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - scoreboard bench for jk_bank_arbiter with directed vectors
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] j_in;
  logic [31:0] k_in;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] gnt;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  jk_bank_arbiter #(
    .N_BITS(8),
    .N_REQ (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .j_in(j_in),
    .k_in(k_in),
    .gnt (gnt),
    .q   (q),
    .qbar(qbar),
    .busy(busy)
  );

  // Monitor: every cycle with a pending expectation, compare the registered outputs.
  always begin
    exp_t e;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt || q !== e.q || qbar !== ~e.q) begin
        errors++;
        $display("FAIL %s: got gnt=%b q=%h qbar=%h, want gnt=%b q=%h qbar=%h",
                 e.name, gnt, q, qbar, e.gnt, e.q, ~e.q);
      end
    end
  end

  // Drive one cycle of inputs, check busy, then queue the expected post-edge state.
  task automatic step(input string name, input logic rst_v, input logic [3:0] r,
                      input logic [31:0] j, input logic [31:0] k,
                      input logic [3:0] exp_gnt, input logic [7:0] exp_q);
    exp_t e;
    rst  = rst_v;
    req  = r;
    j_in = j;
    k_in = k;
    #1;
    checks++;
    if (busy !== (r != 4'b0000)) begin
      errors++;
      $display("FAIL %s busy: got %b want %b", name, busy, (r != 4'b0000));
    end
    @(posedge clk);
    #1;
    e.name = name;
    e.gnt  = exp_gnt;
    e.q    = exp_q;
    sb.push_back(e);
  endtask

  initial begin
    // Reset with all requesters active; no update may leak through.
    step("rst0", 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 8'h00);
    step("rst1", 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 8'h00);
    step("idle_after_rst", 1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0000, 8'h00);

    // Single op from requester 2, then toggle while held (masked one cycle).
    step("single_set", 1'b0, 4'b0100, 32'h00F0_0000, 32'h0000_0000, 4'b0100, 8'hF0);
    step("single_mask", 1'b0, 4'b0100, 32'h00FF_0000, 32'h00FF_0000, 4'b0000, 8'hF0);
    step("single_tog", 1'b0, 4'b0100, 32'h00FF_0000, 32'h00FF_0000, 4'b0100, 8'h0F);

    // rr_ptr is 3 here: requester 0 wins via wrap, then 1.
    step("wrap0", 1'b0, 4'b0011, 32'h0000_2010, 32'h0000_0000, 4'b0001, 8'h1F);
    step("wrap1", 1'b0, 4'b0011, 32'h0000_2010, 32'h0000_0000, 4'b0010, 8'h3F);

    // Reset to restart from pointer 0, then full round-robin.
    step("rst_rr", 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 8'h00);
    step("rr0", 1'b0, 4'b1111, 32'h0804_0201, 32'h0000_0000, 4'b0001, 8'h01);
    step("rr1", 1'b0, 4'b1111, 32'h0804_0201, 32'h0000_0000, 4'b0010, 8'h03);
    step("rr2", 1'b0, 4'b1111, 32'h0804_0201, 32'h0000_0000, 4'b0100, 8'h07);
    step("rr3", 1'b0, 4'b1111, 32'h0804_0201, 32'h0000_0000, 4'b1000, 8'h0F);
    step("rr4", 1'b0, 4'b1111, 32'h0804_0201, 32'h0000_0000, 4'b0001, 8'h0F);

    // Requester 1 alone, held with a toggle on bit 7: grants alternate.
    step("b2b0", 1'b0, 4'b0010, 32'h0000_8000, 32'h0000_8000, 4'b0010, 8'h8F);
    step("b2b1", 1'b0, 4'b0010, 32'h0000_8000, 32'h0000_8000, 4'b0000, 8'h8F);
    step("b2b2", 1'b0, 4'b0010, 32'h0000_8000, 32'h0000_8000, 4'b0010, 8'h0F);
    step("b2b3", 1'b0, 4'b0010, 32'h0000_8000, 32'h0000_8000, 4'b0000, 8'h0F);

    // Reset coincident with a request wins; search restarts at index 0.
    step("rst_mid", 1'b1, 4'b0001, 32'h0000_00FF, 32'h0000_0000, 4'b0000, 8'h00);
    step("post_rst0", 1'b0, 4'b1001, 32'h8000_0001, 32'h0000_0000, 4'b0001, 8'h01);
    step("post_rst1", 1'b0, 4'b1001, 32'h8000_0001, 32'h0000_0000, 4'b1000, 8'h81);

    // Clear via k from requester 2 while requester 3 drops out (cancel).
    step("clear", 1'b0, 4'b0100, 32'hFF00_0000, 32'h0081_0000, 4'b0100, 8'h00);
    step("drain", 1'b0, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 8'h00);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
